// File: rtl/lcrc_pkg.sv
// rtl/lcrc_pkg.sv - shared LCRC constants, FSM state type and CRC helper functions
package lcrc_pkg;

  localparam logic [31:0] LCRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] LCRC_SEED     = 32'h00000000;
  localparam int          LCRC_BYTES    = 4;
  localparam int          MIN_PKT_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } lcrc_state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Bits are consumed LSB first into a non-reflected register.
  function automatic logic [31:0] lcrc_byte_next(input logic [31:0] crc,
                                                 input logic [7:0]  data,
                                                 input logic [31:0] poly = LCRC_POLY);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      fb = c[31] ^ data[k];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/lcrc_32_byte_step.sv
// rtl/lcrc_32_byte_step.sv - combinational one-byte LCRC register update
import lcrc_pkg::*;

module lcrc_32_byte_step #(
  parameter logic [31:0] POLY = LCRC_POLY
) (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  assign crc_next = lcrc_byte_next(crc, data, POLY);

endmodule

// File: rtl/lcrc_32_checker.sv
// rtl/lcrc_32_checker.sv - receive-side LCRC checker: strips and verifies the 4-byte trailer
// Defining LCRC_STATS_EN adds saturating good_count/bad_count outputs.
import lcrc_pkg::*;

module lcrc_32_checker #(
  parameter logic [31:0] CRC_POLY = LCRC_POLY,
  parameter logic [31:0] CRC_SEED = LCRC_SEED
`ifdef LCRC_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       stat_valid,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       abort_err
`ifdef LCRC_STATS_EN
  , output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
`endif
);

  lcrc_state_t state;
  logic [2:0]  cnt;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [7:0]  dl [LCRC_BYTES];
  logic        first;

  logic xfer, start, abort, runt, fwd, done, push, match;

  assign in_ready = !reset && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign start    = xfer && in_sop;
  assign abort    = start && (state != IDLE);
  assign runt     = xfer && in_eop && (in_sop || state == FILL);
  assign fwd      = xfer && !in_sop && (state == STREAM);
  assign done     = fwd && in_eop;
  assign push     = xfer && (in_sop || state != IDLE);

  // dl[0] is the newest byte; on the eop beat dl[2..0] plus in_data form the trailer.
  assign match = (crc_next == {bit_rev8(dl[2]), bit_rev8(dl[1]),
                               bit_rev8(dl[0]), bit_rev8(in_data)});

  lcrc_32_byte_step #(.POLY(CRC_POLY)) u_step (
    .crc      (crc),
    .data     (dl[LCRC_BYTES-1]),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      crc        <= '0;
      first      <= 1'b0;
      for (int i = 0; i < LCRC_BYTES; i++) dl[i] <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      stat_valid <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      if (push) begin
        dl[0] <= in_data;
        for (int i = 1; i < LCRC_BYTES; i++) dl[i] <= dl[i-1];
      end

      if (start) begin
        crc   <= CRC_SEED;
        cnt   <= 3'd1;
        first <= 1'b1;
      end else if (fwd) begin
        crc   <= crc_next;
        first <= 1'b0;
      end else if (push && state == FILL) begin
        cnt <= cnt + 3'd1;
      end

      if (runt || done)
        state <= IDLE;
      else if (start)
        state <= FILL;
      else if (push && state == FILL && cnt == 3'(MIN_PKT_BYTES - 2))
        state <= STREAM;

      if (fwd) begin
        out_valid <= 1'b1;
        out_data  <= dl[LCRC_BYTES-1];
        out_sop   <= first;
        out_eop   <= in_eop;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      stat_valid <= runt || abort || done;
      crc_ok     <= done && match;
      crc_err    <= runt || abort || (done && !match);
      len_err    <= runt;
      abort_err  <= abort;
    end
  end

`ifdef LCRC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_count <= '0;
      bad_count  <= '0;
    end else begin
      if (stat_valid && crc_ok && good_count != '1)
        good_count <= good_count + CNT_W'(1);
      if (stat_valid && crc_err && bad_count != '1)
        bad_count <= bad_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lcrc_32_checker.sv
// tb/tb_lcrc_32_checker.sv - self-checking bench for lcrc_32_checker
module tb_lcrc_32_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_sop, in_eop;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_sop, out_eop;
  logic [7:0] out_data;
  logic       stat_valid, crc_ok, crc_err, len_err, abort_err;
`ifdef LCRC_STATS_EN
  logic [15:0] good_count, bad_count;
`endif

  lcrc_32_checker dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .stat_valid (stat_valid),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .abort_err  (abort_err)
`ifdef LCRC_STATS_EN
    , .good_count (good_count),
    .bad_count  (bad_count)
`endif
  );

  always #5 clk = ~clk;

  // Stat record: {ok, err, len, abort, out_eop beat present}
  typedef struct {
    logic [79:0] b;
    int          len;
    int          nfwd;
    logic [4:0]  st;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] fwd_q [$];
  logic [9:0] exp_q [$];
  logic [4:0] stat_q [$];
  logic [4:0] exp_s [$];
  int         n_checks = 0;
  int         n_fails = 0;
  int         viol = 0;
  logic       bp_en = 1'b0;
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) fwd_q.push_back({out_sop, out_eop, out_data});
      if (stat_valid) stat_q.push_back({crc_ok, crc_err, len_err, abort_err, out_valid && out_eop});
      if (out_valid && !out_ready && in_ready) viol++;
      if (stalled && (!out_valid || out_data != held)) viol++;
      stalled = out_valid && !out_ready;
      held    = out_data;
    end else begin
      stalled = 1'b0;
    end
  end

  always @(posedge clk) if (bp_en) begin #1; out_ready = !out_ready; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Conventional MSB-first CRC over bit-reversed bytes, equivalent to LSB-first processing.
  function automatic logic [31:0] ref_crc6(input logic [47:0] p);
    logic [31:0] c;
    c = 32'h0;
    for (int i = 0; i < 6; i++) begin
      c ^= {rev8(p[47-8*i -: 8]), 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    fwd_q.delete(); exp_q.delete(); stat_q.delete(); exp_s.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    int   n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    check("accept", acc, 1'b1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drain();
    bp_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name);
    int bad;
    check({name, " fwd_count"}, fwd_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++)
      if (fwd_q[i] !== exp_q[i]) bad++;
    check({name, " fwd_bytes_bad"}, bad, 0);
    check({name, " stat_count"}, stat_q.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < stat_q.size(); i++)
      check({name, " stat"}, stat_q[i], exp_s[i]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    clear();
    for (int i = 0; i < v.nfwd; i++)
      exp_q.push_back({i == 0, i == v.nfwd - 1, v.b[79-8*i -: 8]});
    exp_s.push_back(v.st);
    for (int i = 0; i < v.len; i++)
      send_byte(v.b[79-8*i -: 8], i == 0, i == v.len - 1);
    drain();
    compare(name);
  endtask

  initial begin
    logic [47:0] bp_pay;
    logic [31:0] bp_crc;
    logic [79:0] bp_pkt;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h0; in_sop = 1'b0; in_eop = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{{8'h80, 8'h20, 8'h83, 8'hB8, 8'hED, 40'h0}, 5, 1, 5'b10001};
    vecs[1] = '{{8'h80, 8'h20, 8'h83, 8'hB8, 8'hEC, 40'h0}, 5, 1, 5'b01001};
    vecs[2] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 40'h0}, 5, 1, 5'b10001};
    vecs[3] = '{{8'hAA, 8'hBB, 8'hCC, 56'h0}, 3, 0, 5'b01100};
    vecs[4] = '{{8'h11, 8'h22, 8'h33, 8'h44, 48'h0}, 4, 0, 5'b01100};
    vecs[5] = '{{8'h55, 72'h0}, 1, 0, 5'b01100};
    vecs[6] = '{{8'h00, 8'h80, 8'h20, 8'h83, 8'hB8, 8'hED, 32'h0}, 6, 2, 5'b10001};
    vecs[7] = '{{8'hC0, 8'hB0, 8'hC2, 8'h64, 8'h9B, 40'h0}, 5, 1, 5'b10001};

    #12;
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset stat_valid", stat_valid, 1'b0);
    check("reset out_data", out_data, 8'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Stray bytes outside a packet are swallowed silently.
    clear();
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b1);
    drain();
    compare("idle_garbage");

    for (int r = 0; r < 8; r++) run_vec(vecs[r], $sformatf("vec%0d", r));

    // Backpressure: 10-byte packet, out_ready toggling.
    bp_pay = 48'h01_02_03_04_05_06;
    bp_crc = ref_crc6(bp_pay);
    bp_pkt = {bp_pay, rev8(bp_crc[31:24]), rev8(bp_crc[23:16]), rev8(bp_crc[15:8]), rev8(bp_crc[7:0])};
    clear();
    for (int i = 0; i < 6; i++) exp_q.push_back({i == 0, i == 5, bp_pay[47-8*i -: 8]});
    exp_s.push_back(5'b10001);
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(bp_pkt[79-8*i -: 8], i == 0, i == 9);
    drain();
    compare("backpressure");

    // Abort: new sop after 6 bytes, then a good packet.
    clear();
    exp_q.push_back({1'b1, 1'b0, 8'hA0});
    exp_q.push_back({1'b0, 1'b0, 8'hA1});
    exp_q.push_back({1'b1, 1'b1, 8'h80});
    exp_s.push_back(5'b01010);
    exp_s.push_back(5'b10001);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), i == 0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(vecs[0].b[79-8*i -: 8], i == 0, i == 4);
    drain();
    compare("abort");

`ifdef LCRC_STATS_EN
    check("good_count", good_count, 16'd6);
    check("bad_count", bad_count, 16'd5);
`endif

    // Reset mid-STREAM with a stalled payload byte on the output.
    clear();
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), i == 0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid pre out_valid", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid out_valid", out_valid, 1'b0);
    check("rst_mid stat_valid", stat_valid, 1'b0);
    check("rst_mid in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drain();
    check("rst_mid stat_count", stat_q.size(), 0);

    run_vec(vecs[0], "post_reset");

    check("ready_hold_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lcrc_32_checker.md
Name: lcrc_32_checker

Overview:
- Receive-side link CRC checker. Accepts a byte stream of packets, each carrying a 32-bit LCRC in its last 4 bytes.
- Recomputes the LCRC over the payload, strips the 4 CRC bytes, forwards the payload downstream, and reports pass/fail once per packet.
- Sits between the link deframer and the replay/ACK logic.

Parameters:
- CRC_POLY, 32'h04C11DB7, generator polynomial.
- CRC_SEED, 32'h00000000, CRC register value at start of packet.
- CNT_W, 16, width of statistics counters (used only with LCRC_STATS_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  checker can accept the input byte.
- in_data  in  8  input byte.
- in_sop  in  1  first byte of packet.
- in_eop  in  1  last byte of packet (last CRC byte).
- out_valid  out  1  payload byte valid.
- out_ready  in  1  downstream accepts the payload byte.
- out_data  out  8  payload byte.
- out_sop  out  1  first payload byte.
- out_eop  out  1  last payload byte.
- stat_valid  out  1  one-cycle pulse, status fields valid.
- crc_ok  out  1  packet CRC matched.
- crc_err  out  1  CRC mismatch, runt packet, or aborted packet.
- len_err  out  1  runt packet (fewer than 5 bytes).
- abort_err  out  1  packet cut short by a new in_sop.
- good_count / bad_count  out  CNT_W  only with LCRC_STATS_EN.

Behaviour:
- Reset: all outputs 0; in_ready 0 while reset is asserted, then 1; FSM goes to IDLE; delay line and CRC register cleared.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - Output is a single registered stage; out_* hold steady while out_valid && !out_ready.
- CRC algorithm:
  - Per byte, process bits k=0..7 (LSB first): fb = c[31]^d[k]; c = {c[30:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - No final XOR.
  - The expected wire CRC is c with each byte bit-reversed, sent c[31:24] first.
- Delay line: 4-byte shift register. A byte feeds the CRC and goes downstream only when it is evicted, so CRC bytes are never forwarded.
- FSM states:
  - IDLE: wait for in_sop. On the sop transfer, load c=CRC_SEED, push the byte, cnt=1, go to FILL.
  - FILL: push bytes until cnt=4, then go to STREAM.
    - in_eop in FILL (packet of 4 bytes or fewer): drop the packet; stat pulse with crc_err=1, len_err=1; nothing forwarded; go to IDLE.
  - STREAM: each transfer evicts the oldest byte to the output (out_sop on the first evicted byte of the packet) and updates the CRC with it.
    - On in_eop: the evicted byte carries out_eop=1. Compare next-CRC against {d[2],d[1],d[0],in_data} after per-byte reversal.
    - In the same cycle the out_eop beat is registered, pulse stat_valid with crc_ok or crc_err. Return to IDLE.
- Latency: a payload byte appears on out_data 1 cycle after the transfer that evicts it. Status coincides with the out_eop beat.
- in_sop while in FILL or STREAM: current packet aborted; stat pulse with crc_err=1, abort_err=1.
  - If the aborted packet had payload in flight, the last forwarded byte is not marked eop; downstream relies on crc_err.
  - The new byte starts a fresh packet (FILL, cnt=1).
- in_sop && in_eop on the same byte: runt, handled as above.
- Bytes with in_valid outside a packet (IDLE, no sop): consumed and ignored.
- Reset mid-packet: packet discarded, no status pulse.

Optional Feature:
- LCRC_STATS_EN defined:
  - good_count increments on every crc_ok pulse; bad_count increments on every crc_err pulse.
  - Both saturate at all-ones and reset to 0.
- LCRC_STATS_EN undefined: the counter ports and logic are absent.

Decomposition:
- Package lcrc_pkg holds:
  - constants: LCRC_POLY, LCRC_SEED, LCRC_BYTES=4, MIN_PKT_BYTES=5;
  - FSM state typedef (IDLE, FILL, STREAM);
  - function bit_rev8;
  - function lcrc_byte_next(crc, byte).
- One sub-module, lcrc_32_byte_step: combinational 8-bit CRC update, instantiated once.

Test Plan:
- Good packet: send 80 20 83 B8 ED (sop on 80, eop on ED) -> out 80 with sop+eop; crc_ok=1, crc_err=0 on the same cycle.
- Corrupted CRC: send 80 20 83 B8 EC -> 80 forwarded; crc_err=1, len_err=0.
- Zero payload: send 00 00 00 00 00 -> 00 forwarded; crc_ok=1.
- Runt: send 3 bytes AA BB CC (eop on CC) -> nothing forwarded; crc_err=1, len_err=1.
- Backpressure: 10-byte packet with out_ready toggled every other cycle -> payload order intact; in_ready low while out_valid && !out_ready; single status pulse.
- Abort and reset:
  - New sop after 6 bytes -> abort_err=1 pulse, then the next packet checks correctly.
  - reset asserted mid-STREAM -> outputs 0 immediately, no status pulse.
